// File: rtl/wlo_ctrl_unit.sv
// Byte-serial command/control unit for the word-length-optimisation emulator.
// Optional checksum byte on loads and responses: define WLO_CTRL_CHKSUM_EN.
module wlo_ctrl_unit #(
  parameter int         NUM_CHAN = 15,
  parameter int         NUM_PATH = 2,
  parameter int         MSE_W    = 64,
  parameter logic [7:0] SW_RST   = 8'h1E,
  parameter int         TIMEOUT  = 65535,
  parameter int         RST_CYC  = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           com_rxvalid,
  input  logic [7:0]                     com_rxdata,
  output logic                           com_txvalid,
  output logic [7:0]                     com_txdata,
  input  logic                           com_txready,
  input  logic [NUM_PATH*MSE_W-1:0]      mse_data,
  input  logic                           mse_valid,
  output logic [NUM_PATH*NUM_CHAN*8-1:0] sw_int,
  output logic [NUM_PATH*NUM_CHAN*8-1:0] sw_frac,
  output logic                           start,
  output logic                           soft_rstn,
  output logic                           busy,
  output logic                           err
);

  localparam int N = NUM_PATH * NUM_CHAN;
  localparam int M = NUM_PATH * MSE_W / 8;
`ifdef WLO_CTRL_CHKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int RTN_LEN = M + CK;
  localparam int RDB_LEN = 2 * N + CK;
  localparam int TX_MAX  = (RTN_LEN > RDB_LEN) ? RTN_LEN : RDB_LEN;
  localparam int TX_W    = $clog2(TX_MAX + 1);
  localparam int LD_W    = $clog2(N + CK + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);
  localparam int RC_W    = $clog2(RST_CYC + 1);

  typedef enum logic [2:0] {IDLE, FLOAD, ILOAD, START, SRST, RETRN, RDBK} state_t;

  state_t                    state;
  logic [N*8-1:0]            shadow;
  logic [LD_W-1:0]           sh_idx;
  logic [TO_W-1:0]           to_cnt;
  logic [RC_W-1:0]           rc_cnt;
  logic [TX_W-1:0]           tx_idx, tx_len;
  logic [NUM_PATH*MSE_W-1:0] cap, tx_buf;
  logic                      mse_pend;
`ifdef WLO_CTRL_CHKSUM_EN
  logic [7:0]                rx_sum, tx_sum;
`endif

  logic [TX_W-1:0] tx_nxt;
  logic [7:0]      tx_pick;
  logic [N*8-1:0]  live_sw;
  logic [N*8-1:0]  shadow_mrg;

  // NOTE: combinational logic uses blocking '=' and assigns every output first,
  // so no latch is inferred; the clocked block below uses '<=' only.
  always_comb begin
    tx_nxt  = tx_idx + 1'b1;
    tx_pick = (state == RETRN) ? 8'(tx_buf >> {tx_nxt, 3'b000})
                               : 8'({sw_int, sw_frac} >> {tx_nxt, 3'b000});
    live_sw = (state == FLOAD) ? sw_frac : sw_int;
    shadow_mrg = shadow;
`ifndef WLO_CTRL_CHKSUM_EN
    // The final frame byte is merged in so the commit sees the complete frame.
    shadow_mrg[sh_idx*8 +: 8] = com_rxdata;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      sw_int      <= {N{SW_RST}};
      sw_frac     <= {N{SW_RST}};
      // NOTE: the shadow is a register array but has a defined reset value
      // because a timed-out frame reloads it and readback must be deterministic.
      shadow      <= {N{SW_RST}};
      start       <= 1'b0;
      soft_rstn   <= 1'b1;
      com_txvalid <= 1'b0;
      com_txdata  <= 8'h00;
      busy        <= 1'b0;
      err         <= 1'b0;
      mse_pend    <= 1'b0;
      cap         <= '0;
      tx_buf      <= '0;
      sh_idx      <= '0;
      to_cnt      <= '0;
      rc_cnt      <= '0;
      tx_idx      <= '0;
      tx_len      <= '0;
`ifdef WLO_CTRL_CHKSUM_EN
      rx_sum      <= 8'h00;
      tx_sum      <= 8'h00;
`endif
    end else begin
      err   <= 1'b0;
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (com_rxvalid) begin
            case (com_rxdata)
              8'h01: begin state <= START; busy <= 1'b1; start <= 1'b1; end
              8'h02, 8'h03: begin
                state  <= (com_rxdata == 8'h02) ? FLOAD : ILOAD;
                busy   <= 1'b1;
                sh_idx <= '0;
                to_cnt <= '0;
`ifdef WLO_CTRL_CHKSUM_EN
                rx_sum <= 8'h00;
`endif
              end
              8'h04: begin
                state     <= SRST;
                busy      <= 1'b1;
                soft_rstn <= 1'b0;
                rc_cnt    <= RC_W'(RST_CYC - 1);
              end
              8'h05: begin
                state       <= RDBK;
                busy        <= 1'b1;
                com_txvalid <= 1'b1;
                com_txdata  <= sw_frac[7:0];
                tx_idx      <= '0;
                tx_len      <= TX_W'(RDB_LEN);
`ifdef WLO_CTRL_CHKSUM_EN
                tx_sum      <= sw_frac[7:0];
`endif
              end
              default: err <= 1'b1;
            endcase
          end else if (mse_pend) begin
            // Snapshot so a result arriving on this very cycle cannot disturb the reply.
            state       <= RETRN;
            busy        <= 1'b1;
            mse_pend    <= 1'b0;
            tx_buf      <= cap;
            com_txvalid <= 1'b1;
            com_txdata  <= cap[7:0];
            tx_idx      <= '0;
            tx_len      <= TX_W'(RTN_LEN);
`ifdef WLO_CTRL_CHKSUM_EN
            tx_sum      <= cap[7:0];
`endif
          end
        end
        START: begin state <= IDLE; busy <= 1'b0; end
        SRST: begin
          if (rc_cnt == '0) begin
            soft_rstn <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            rc_cnt <= rc_cnt - 1'b1;
          end
        end
        FLOAD, ILOAD: begin
          if (com_rxvalid) begin
            to_cnt <= '0;
            sh_idx <= sh_idx + 1'b1;
`ifdef WLO_CTRL_CHKSUM_EN
            if (sh_idx == LD_W'(N)) begin
              if (com_rxdata == rx_sum) begin
                if (state == FLOAD) sw_frac <= shadow;
                else                sw_int  <= shadow;
              end else begin
                err    <= 1'b1;
                shadow <= live_sw;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              shadow[sh_idx*8 +: 8] <= com_rxdata;
              rx_sum                <= rx_sum ^ com_rxdata;
            end
`else
            shadow <= shadow_mrg;
            if (sh_idx == LD_W'(N - 1)) begin
              if (state == FLOAD) sw_frac <= shadow_mrg;
              else                sw_int  <= shadow_mrg;
              state <= IDLE;
              busy  <= 1'b0;
            end
`endif
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            err    <= 1'b1;
            shadow <= live_sw;
            state  <= IDLE;
            busy   <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RETRN, RDBK: begin
          if (com_txready) begin
            if (tx_idx == tx_len - 1'b1) begin
              com_txvalid <= 1'b0;
              state       <= IDLE;
              busy        <= 1'b0;
            end else begin
              tx_idx <= tx_nxt;
`ifdef WLO_CTRL_CHKSUM_EN
              if (tx_nxt == tx_len - 1'b1) begin
                com_txdata <= tx_sum;
              end else begin
                com_txdata <= tx_pick;
                tx_sum     <= tx_sum ^ tx_pick;
              end
`else
              com_txdata <= tx_pick;
`endif
            end
          end
        end
        default: begin state <= IDLE; busy <= 1'b0; end
      endcase

      if (com_rxvalid && (state inside {START, SRST, RETRN, RDBK})) err <= 1'b1;

      if (mse_valid) begin
        if (state == RETRN) begin
          err <= 1'b1;
        end else begin
          cap      <= mse_data;
          mse_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wlo_ctrl_unit.sv
// Scoreboard bench for wlo_ctrl_unit: expected TX bytes are queued by the
// stimulus and popped by a monitor at every accepted transfer.
module tb_wlo_ctrl_unit;

  localparam int NC = 15;
  localparam int NP = 2;
  localparam int MW = 64;
  localparam int N  = NC * NP;

  logic              clk = 1'b0;
  logic              rstn;
  logic              com_rxvalid;
  logic [7:0]        com_rxdata;
  logic              com_txvalid;
  logic [7:0]        com_txdata;
  logic              com_txready = 1'b1;
  logic [NP*MW-1:0]  mse_data;
  logic              mse_valid;
  logic [N*8-1:0]    sw_int, sw_frac;
  logic              start, soft_rstn, busy, err;

  wlo_ctrl_unit #(
    .NUM_CHAN(NC), .NUM_PATH(NP), .MSE_W(MW),
    .SW_RST(8'h1E), .TIMEOUT(65535), .RST_CYC(4)
  ) dut (
    .clk(clk), .rstn(rstn),
    .com_rxvalid(com_rxvalid), .com_rxdata(com_rxdata),
    .com_txvalid(com_txvalid), .com_txdata(com_txdata), .com_txready(com_txready),
    .mse_data(mse_data), .mse_valid(mse_valid),
    .sw_int(sw_int), .sw_frac(sw_frac),
    .start(start), .soft_rstn(soft_rstn), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         err_cnt = 0;
  int         start_cnt = 0;
  logic [7:0] exp_q[$];
  bit         rdy_mode = 1'b0;
  int         rcnt = 0;
  bit         stall_pend = 1'b0;
  logic [7:0] held = 8'h00;
  logic [N*8-1:0] all_rst, exp_frac;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // TX sink ready: constant 1, or the 1,0,0 repeating pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      com_txready = rdy_mode ? (rcnt % 3 == 0) : 1'b1;
      rcnt++;
    end
  end

  // Monitor: pulse counters, hold-while-stalled checks and scoreboard pops.
  always @(negedge clk) begin
    if (rstn) begin
      if (err)   err_cnt++;
      if (start) start_cnt++;
      if (stall_pend) begin
        check("tx_hold_valid", 256'(com_txvalid), 256'(1));
        check("tx_hold_data", 256'(com_txdata), 256'(held));
      end
      stall_pend = com_txvalid && !com_txready;
      held       = com_txdata;
      if (com_txvalid && com_txready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL tx_extra: got %0h, want no byte", com_txdata);
        end else begin
          check("tx_byte", 256'(com_txdata), 256'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    com_rxvalid = 1'b1;
    com_rxdata  = b;
    tick();
    com_rxvalid = 1'b0;
  endtask

  task automatic drain(input string name, input int lim);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < lim) begin
      tick();
      n++;
    end
    check(name, 256'(n < lim), 256'(1));
  endtask

  logic [7:0] v1[16] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01,
                         8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
  logic [7:0] v2[16] = '{8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11,
                         8'h00, 8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99};

  initial begin
    int n;
    int e0, s0;
    com_rxvalid = 1'b0;
    com_rxdata  = 8'h00;
    mse_valid   = 1'b0;
    mse_data    = '0;
    rstn        = 1'b0;
    for (int k = 0; k < N; k++) begin
      all_rst[k*8 +: 8]  = 8'h1E;
      exp_frac[k*8 +: 8] = 8'(k);
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_sw_int", 256'(sw_int), 256'(all_rst));
    check("rst_sw_frac", 256'(sw_frac), 256'(all_rst));
    check("rst_start", 256'(start), 256'(0));
    check("rst_soft_rstn", 256'(soft_rstn), 256'(1));
    check("rst_txvalid", 256'(com_txvalid), 256'(0));
    check("rst_txdata", 256'(com_txdata), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    rstn = 1'b1;
    tick();

    // Readback of reset switches: 60 bytes of 0x1E back-to-back
    for (int k = 0; k < 2 * N; k++) exp_q.push_back(8'h1E);
    send_byte(8'h05);
    n = 0;
    while (com_txvalid && n < 200) begin
      n++;
      tick();
    end
    check("rdbk_valid_run", 256'(n), 256'(60));
    check("rdbk_busy_after", 256'(busy), 256'(0));
    check("rdbk_sb_empty", 256'(exp_q.size()), 256'(0));

    // Fraction load: atomic update on the last byte
    send_byte(8'h02);
    for (int k = 0; k < N - 1; k++) send_byte(8'(k));
    check("fload_before_last", 256'(sw_frac), 256'(all_rst));
    send_byte(8'(N - 1));
    check("fload_frac", 256'(sw_frac), 256'(exp_frac));
    check("fload_int_kept", 256'(sw_int), 256'(all_rst));
    check("fload_busy", 256'(busy), 256'(0));

    // Readback shows new fractions then unchanged integers
    for (int k = 0; k < N; k++) exp_q.push_back(8'(k));
    for (int k = 0; k < N; k++) exp_q.push_back(8'h1E);
    send_byte(8'h05);
    drain("rdbk2_drain", 200);

    // Integer load abandoned: timeout after 65535 idle cycles
    e0 = err_cnt;
    send_byte(8'h03);
    for (int k = 0; k < 10; k++) send_byte(8'(8'h40 + k));
    n = 0;
    while (!err && n < 70000) begin
      tick();
      n++;
    end
    check("timeout_cycles", 256'(n), 256'(65535));
    tick();
    check("timeout_err_once", 256'(err_cnt - e0), 256'(1));
    check("timeout_int_kept", 256'(sw_int), 256'(all_rst));
    check("timeout_idle", 256'(busy), 256'(0));
    s0 = start_cnt;
    send_byte(8'h01);
    check("start_high", 256'(start), 256'(1));
    tick();
    check("start_low", 256'(start), 256'(0));
    check("start_once", 256'(start_cnt - s0), 256'(1));

    // MSE return with a stalling sink
    e0 = err_cnt;
    rdy_mode = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(v1[k]);
    mse_data  = {64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
    mse_valid = 1'b1;
    tick();
    mse_valid = 1'b0;
    drain("mse1_drain", 500);
    check("mse1_no_err", 256'(err_cnt - e0), 256'(0));

    // Simultaneous command and result: start first, then return; late result dropped
    e0 = err_cnt;
    for (int k = 0; k < 16; k++) exp_q.push_back(v2[k]);
    mse_data    = {64'h99AABBCCDDEEFF00, 64'h1122334455667788};
    mse_valid   = 1'b1;
    com_rxvalid = 1'b1;
    com_rxdata  = 8'h01;
    tick();
    mse_valid   = 1'b0;
    com_rxvalid = 1'b0;
    check("both_start_first", 256'(start), 256'(1));
    check("both_tx_not_yet", 256'(com_txvalid), 256'(0));
    n = 0;
    while (!com_txvalid && n < 10) begin
      tick();
      n++;
    end
    check("both_tx_begins", 256'(n < 10), 256'(1));
    mse_data  = {64'hDEADBEEFDEADBEEF, 64'hCAFEF00DCAFEF00D};
    mse_valid = 1'b1;
    tick();
    mse_valid = 1'b0;
    drain("mse2_drain", 500);
    check("mse2_err_once", 256'(err_cnt - e0), 256'(1));
    rdy_mode = 1'b0;
    repeat (4) tick();
    check("mse2_no_resend", 256'(com_txvalid), 256'(0));
    check("mse2_idle", 256'(busy), 256'(0));

    // Soft reset pulse width
    send_byte(8'h04);
    n = 0;
    while (!soft_rstn && n < 20) begin
      n++;
      tick();
    end
    check("srst_width", 256'(n), 256'(4));
    check("srst_frac_kept", 256'(sw_frac), 256'(exp_frac));

    // Unknown command
    s0 = start_cnt;
    send_byte(8'h7F);
    check("bad_cmd_err", 256'(err), 256'(1));
    check("bad_cmd_idle", 256'(busy), 256'(0));
    tick();
    check("bad_cmd_err_pulse", 256'(err), 256'(0));
    check("bad_cmd_no_start", 256'(start_cnt - s0), 256'(0));

    check("sb_left", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wlo_ctrl_unit.md
Name: wlo_ctrl_unit

Overview:
- Byte-serial command/control unit for the word-length-optimisation emulator: decodes PC commands, loads per-path/per-channel integer and fraction bit switches, pulses start and soft reset, and returns MSE results.
- Successor to the fixed 2-path controller.
  - Path count, channel count, MSE width and reset pulse length are parametrised.
  - Adds a TX ready handshake, atomic shadowed switch loading, switch readback, RX timeout and an error flag.
- Sits between the UART byte interface and the emulation core.

Parameters:
NUM_CHAN, 15, channels per path
NUM_PATH, 2, parallel emulation paths (MSE results)
MSE_W, 64, bits per MSE result; multiple of 8
SW_RST, 8'h1E, reset value of every switch byte
TIMEOUT, 65535, max idle cycles between frame bytes
RST_CYC, 4, soft_rstn low duration in cycles (>=1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
com_rxvalid  in  1  RX byte strobe, one cycle per byte
com_rxdata  in  8  RX byte
com_txvalid  out  1  TX byte valid
com_txdata  out  8  TX byte
com_txready  in  1  TX sink accepts byte
mse_data  in  NUM_PATH*MSE_W  path p at [p*MSE_W +: MSE_W]
mse_valid  in  1  MSE result strobe
sw_int  out  NUM_PATH*NUM_CHAN*8  integer switches, entry k=p*NUM_CHAN+c at [k*8 +: 8]
sw_frac  out  NUM_PATH*NUM_CHAN*8  fraction switches, same layout
start  out  1  emulation start pulse
soft_rstn  out  1  emulation soft reset, active low
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle error pulse

Behaviour:
- All outputs registered. Reset values: sw_int and sw_frac all bytes SW_RST; shadow equal; start=0, soft_rstn=1, com_txvalid=0, com_txdata=0, busy=0, err=0; mse_pend=0; state IDLE.
- N = NUM_PATH*NUM_CHAN. M = NUM_PATH*MSE_W/8.
- States: IDLE, FLOAD, ILOAD, START, SRST, RETRN, RDBK.
- IDLE commands (byte with rxvalid); each command is acted on the cycle after the byte:
  - 01: START.
  - 02: FLOAD.
  - 03: ILOAD.
  - 04: SRST.
  - 05: RDBK.
  - Other byte: err pulse, stay IDLE.
  - A received byte has priority over pending MSE.
  - Otherwise, mse_pend moves to RETRN.
- START: start=1 for exactly one cycle, then IDLE.
- SRST: soft_rstn=0 for RST_CYC cycles, then IDLE. Switch values retained.
- FLOAD/ILOAD frame:
  - Next N bytes are written to shadow entries 0..N-1 in order; index counter starts at 0.
  - On byte N, the whole shadow is copied to sw_frac or sw_int in the same cycle (atomic update), then IDLE.
  - Idle-cycle counter resets on each byte. If it reaches TIMEOUT: err pulse, shadow discarded (reloaded from live outputs), IDLE.
- MSE capture:
  - mse_valid outside RETRN latches mse_data into the capture register and sets mse_pend (a newer result overwrites an unsent one).
  - mse_valid in RETRN: dropped, err pulse.
- RETRN:
  - Sends M bytes, little-endian, path 0 first (byte 0 = mse_data[7:0]).
  - mse_pend cleared on entry.
- RDBK: sends N sw_frac bytes, then N sw_int bytes, entry 0 first.
- TX handshake:
  - A byte transfers on com_txvalid && com_txready.
  - com_txdata and com_txvalid are held stable while !com_txready.
  - The next byte is presented the cycle after a transfer, so back-to-back transfers are possible.
  - com_txvalid drops the cycle after the last transfer; the state returns to IDLE at the same time.
- RX bytes arriving in START, SRST, RETRN or RDBK: ignored, err pulse.
- Async reset mid-frame or mid-transmit aborts immediately to the reset values.

Optional Feature:
- Macro: WLO_CTRL_CHKSUM_EN.
- Defined:
  - RETRN and RDBK append one extra byte: XOR of all preceding bytes of that response.
  - FLOAD/ILOAD expect one extra byte after entry N-1: XOR of the N data bytes.
  - On checksum mismatch: err pulse, shadow discarded, outputs unchanged.
- Undefined: no checksum byte sent or expected; lengths exactly M, 2N, N.

Test Plan:
- Reset, then command 05 with txready=1 -> 60 bytes all 0x1E, txvalid high 60 consecutive cycles, busy low after.
- Command 02 followed by bytes 0x00..0x1D -> sw_frac entry k = k, all entries updated in the same cycle; sw_int unchanged at 0x1E.
- Command 03, then 10 bytes, then 65535 idle cycles -> err pulse, sw_int unchanged, state IDLE; the next 01 gives a single-cycle start.
- mse_valid with path0=64'h0123456789ABCDEF, path1=64'hFEDCBA9876543210; txready toggling 1,0,0,1,... -> 16 bytes EF,CD,AB,89,67,45,23,01,10,32,54,76,98,BA,DC,FE; data stable while stalled.
- mse_valid and rx byte 01 in the same IDLE cycle -> start pulse first, then the MSE return; a second mse_valid during RETRN -> err pulse, the in-flight bytes unchanged.
- Command 04 with RST_CYC=4 -> soft_rstn low exactly 4 cycles; unknown byte 0x7F -> err pulse only.
